// File: rtl/jtframe_board_pkg.sv
// Shared constants and types for the MiST board glue: raw joystick bit map,
// reset counter limit and the SDRAM programming-write payload.
package jtframe_board_pkg;

    localparam int unsigned JOY_START   = 10;
    localparam int unsigned JOY_COIN    = 11;
    localparam int unsigned JOY_PAUSE   = 12;
    localparam int unsigned JOY_SERVICE = 13;

    localparam int unsigned RST_CNT_W = 8;
    localparam logic [RST_CNT_W-1:0] RST_CNT_MAX = 8'd255;

    localparam int unsigned ADDR_W  = 22;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned JOY_W   = 10;
    localparam int unsigned RAW_W   = 16;
    localparam int unsigned COLOR_W = 6;
    localparam int unsigned SND_W   = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BYTE_W-1:0] data;
        logic [1:0]        mask;
        logic              we;
    } prog_t;

    // Widen a 4-bit colour to 6 bits by replicating its top bits.
    function automatic logic [COLOR_W-1:0] expand_color(input logic [3:0] c);
        return {c, c[3:2]};
    endfunction

endpackage

// File: rtl/jtframe_sigmadelta.sv
// First-order sigma-delta DAC: the carry out of a 16-bit phase accumulator
// is the 1-bit output stream.
module jtframe_sigmadelta
    import jtframe_board_pkg::*;
#(
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SND_W-1:0] din_i,
    output logic             dout_o
);

    logic [SND_W-1:0] u_c;
    logic [SND_W:0]   acc_q;
    logic [SND_W:0]   acc_d;

    // Two's complement samples are re-biased to offset binary.
    always_comb begin
        u_c   = SIGNED ? (din_i ^ 16'h8000) : din_i;
        acc_d = {1'b0, acc_q[SND_W-1:0]} + {1'b0, u_c};
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign dout_o = acc_q[SND_W];

endmodule

// File: rtl/jtframe_mist_board.sv
// Board glue between the MiST I/O layer and the game core: reset sequencing,
// ROM download to SDRAM writes, input conditioning, VGA colour and audio DACs.
module jtframe_mist_board
#(
    parameter bit SIGNED_SND             = 1'b0,
    parameter bit THREE_BUTTONS          = 1'b0,
    parameter bit GAME_INPUTS_ACTIVE_LOW = 1'b0
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        pll_locked,
    input  logic        rst_req,
    output logic        rst_n,
    output logic        game_rst_n,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    input  logic [15:0] joy1_raw,
    input  logic [15:0] joy2_raw,
    output logic [9:0]  game_joystick1,
    output logic [9:0]  game_joystick2,
    output logic [1:0]  game_coin,
    output logic [1:0]  game_start,
    output logic        game_pause,
    output logic        game_service,
    input  logic        pxl_cen,
    input  logic [3:0]  game_r,
    input  logic [3:0]  game_g,
    input  logic [3:0]  game_b,
    input  logic        LHBL,
    input  logic        LVBL,
    input  logic        hs,
    input  logic        vs,
    output logic [5:0]  VGA_R,
    output logic [5:0]  VGA_G,
    output logic [5:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    input  logic [15:0] snd_left,
    input  logic [15:0] snd_right,
    output logic        AUDIO_L,
    output logic        AUDIO_R,
    output logic        LED
);
    import jtframe_board_pkg::*;

    localparam logic [JOY_W-1:0] JOY_INV  = {JOY_W{GAME_INPUTS_ACTIVE_LOW}};
    localparam logic [1:0]       PAIR_INV = {2{GAME_INPUTS_ACTIVE_LOW}};
    localparam prog_t PROG_RST = '{addr: '0, data: '0, mask: 2'b11, we: 1'b0};

    function automatic logic [JOY_W-1:0] cond_joy(input logic [RAW_W-1:0] raw);
        logic [JOY_W-1:0] j;
        j = raw[JOY_W-1:0];
        if (THREE_BUTTONS) j[9:7] = 3'b000;
        return j ^ JOY_INV;
    endfunction

    logic                 hold_c;
    logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic                 rst_n_q, game_rst_n_q, game_rst_n_d;
    prog_t                prog_q, prog_d;
    logic [JOY_W-1:0]     joy1_q, joy2_q;
    logic [1:0]           coin_q, start_q;
    logic                 pause_q, service_q;
    logic [COLOR_W-1:0]   vga_r_q, vga_g_q, vga_b_q;
    logic                 vga_hs_q, vga_vs_q;
    logic                 blank_c;
    logic                 led_q;
    logic                 unused_c;

    assign hold_c   = rst | ~pll_locked | downloading | rst_req;
    assign blank_c  = ~LHBL | ~LVBL;
    assign unused_c = ^{joy1_raw[RAW_W-1:JOY_SERVICE+1], joy2_raw[RAW_W-1:JOY_SERVICE+1]};

    // Release counter restarts whenever any hold source is active.
    always_comb begin
        rst_cnt_d = rst_cnt_q;
        if (hold_c)                        rst_cnt_d = '0;
        else if (rst_cnt_q != RST_CNT_MAX) rst_cnt_d = rst_cnt_q + 1'b1;
        game_rst_n_d = ~hold_c & (rst_cnt_q == RST_CNT_MAX);
    end

    // Byte downloads become word writes; address bit 0 selects the lane.
    always_comb begin
        prog_d    = prog_q;
        prog_d.we = 1'b0;
        if (ioctl_wr & downloading) begin
            prog_d.addr = {1'b0, ioctl_addr[ADDR_W-1:1]};
            prog_d.data = ioctl_data;
            prog_d.mask = ioctl_addr[0] ? 2'b01 : 2'b10;
            prog_d.we   = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            rst_n_q      <= 1'b0;
            rst_cnt_q    <= '0;
            game_rst_n_q <= 1'b0;
            prog_q       <= PROG_RST;
            joy1_q       <= JOY_INV;
            joy2_q       <= JOY_INV;
            coin_q       <= PAIR_INV;
            start_q      <= PAIR_INV;
            pause_q      <= 1'b0;
            service_q    <= GAME_INPUTS_ACTIVE_LOW;
            vga_r_q      <= '0;
            vga_g_q      <= '0;
            vga_b_q      <= '0;
            vga_hs_q     <= 1'b0;
            vga_vs_q     <= 1'b0;
            led_q        <= 1'b0;
        end else begin
            rst_n_q      <= 1'b1;
            rst_cnt_q    <= rst_cnt_d;
            game_rst_n_q <= game_rst_n_d;
            prog_q       <= prog_d;
            joy1_q       <= cond_joy(joy1_raw);
            joy2_q       <= cond_joy(joy2_raw);
            coin_q       <= {joy2_raw[JOY_COIN], joy1_raw[JOY_COIN]} ^ PAIR_INV;
            start_q      <= {joy2_raw[JOY_START], joy1_raw[JOY_START]} ^ PAIR_INV;
            pause_q      <= joy1_raw[JOY_PAUSE] | joy2_raw[JOY_PAUSE];
            service_q    <= (joy1_raw[JOY_SERVICE] | joy2_raw[JOY_SERVICE]) ^ GAME_INPUTS_ACTIVE_LOW;
            led_q        <= downloading;
            if (pxl_cen) begin
                vga_r_q  <= blank_c ? '0 : expand_color(game_r);
                vga_g_q  <= blank_c ? '0 : expand_color(game_g);
                vga_b_q  <= blank_c ? '0 : expand_color(game_b);
                vga_hs_q <= hs;
                vga_vs_q <= vs;
            end
        end
    end

    jtframe_sigmadelta #(.SIGNED(SIGNED_SND)) u_sd_left (
        .clk    (clk_sys),
        .rst    (rst),
        .din_i  (snd_left),
        .dout_o (AUDIO_L)
    );

    jtframe_sigmadelta #(.SIGNED(SIGNED_SND)) u_sd_right (
        .clk    (clk_sys),
        .rst    (rst),
        .din_i  (snd_right),
        .dout_o (AUDIO_R)
    );

    assign rst_n          = rst_n_q;
    assign game_rst_n     = game_rst_n_q;
    assign prog_addr      = prog_q.addr;
    assign prog_data      = prog_q.data;
    assign prog_mask      = prog_q.mask;
    assign prog_we        = prog_q.we;
    assign game_joystick1 = joy1_q;
    assign game_joystick2 = joy2_q;
    assign game_coin      = coin_q;
    assign game_start     = start_q;
    assign game_pause     = pause_q;
    assign game_service   = service_q;
    assign VGA_R          = vga_r_q;
    assign VGA_G          = vga_g_q;
    assign VGA_B          = vga_b_q;
    assign VGA_HS         = vga_hs_q;
    assign VGA_VS         = vga_vs_q;
    assign LED            = led_q;

endmodule

// File: tb/tb_jtframe_mist_board.sv
// Randomized bench for jtframe_mist_board: two instances (default parameters
// and all parameters set) checked every cycle against a behavioural model.
module tb_jtframe_mist_board;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        rst, pll_locked, rst_req, downloading, ioctl_wr;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic [15:0] joy1_raw, joy2_raw, snd_left, snd_right;
    logic        pxl_cen, LHBL, LVBL, hs, vs;
    logic [3:0]  game_r, game_g, game_b;

    logic        rst_n_o [2], game_rst_n_o [2], prog_we_o [2];
    logic [21:0] prog_addr_o [2];
    logic [7:0]  prog_data_o [2];
    logic [1:0]  prog_mask_o [2], coin_o [2], start_o [2];
    logic [9:0]  joy1_o [2], joy2_o [2];
    logic        pause_o [2], service_o [2], hs_o [2], vs_o [2];
    logic [5:0]  r_o [2], g_o [2], b_o [2];
    logic        al_o [2], ar_o [2], led_o [2];

    int n_vec = 0;
    int n_err = 0;
    bit started = 1'b0;

    jtframe_mist_board dut0 (
        .clk_sys(clk_sys), .rst(rst), .pll_locked(pll_locked), .rst_req(rst_req),
        .rst_n(rst_n_o[0]), .game_rst_n(game_rst_n_o[0]), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr_o[0]), .prog_data(prog_data_o[0]), .prog_mask(prog_mask_o[0]),
        .prog_we(prog_we_o[0]), .joy1_raw(joy1_raw), .joy2_raw(joy2_raw),
        .game_joystick1(joy1_o[0]), .game_joystick2(joy2_o[0]), .game_coin(coin_o[0]),
        .game_start(start_o[0]), .game_pause(pause_o[0]), .game_service(service_o[0]),
        .pxl_cen(pxl_cen), .game_r(game_r), .game_g(game_g), .game_b(game_b),
        .LHBL(LHBL), .LVBL(LVBL), .hs(hs), .vs(vs), .VGA_R(r_o[0]), .VGA_G(g_o[0]),
        .VGA_B(b_o[0]), .VGA_HS(hs_o[0]), .VGA_VS(vs_o[0]), .snd_left(snd_left),
        .snd_right(snd_right), .AUDIO_L(al_o[0]), .AUDIO_R(ar_o[0]), .LED(led_o[0])
    );

    jtframe_mist_board #(.SIGNED_SND(1'b1), .THREE_BUTTONS(1'b1), .GAME_INPUTS_ACTIVE_LOW(1'b1)) dut1 (
        .clk_sys(clk_sys), .rst(rst), .pll_locked(pll_locked), .rst_req(rst_req),
        .rst_n(rst_n_o[1]), .game_rst_n(game_rst_n_o[1]), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr_o[1]), .prog_data(prog_data_o[1]), .prog_mask(prog_mask_o[1]),
        .prog_we(prog_we_o[1]), .joy1_raw(joy1_raw), .joy2_raw(joy2_raw),
        .game_joystick1(joy1_o[1]), .game_joystick2(joy2_o[1]), .game_coin(coin_o[1]),
        .game_start(start_o[1]), .game_pause(pause_o[1]), .game_service(service_o[1]),
        .pxl_cen(pxl_cen), .game_r(game_r), .game_g(game_g), .game_b(game_b),
        .LHBL(LHBL), .LVBL(LVBL), .hs(hs), .vs(vs), .VGA_R(r_o[1]), .VGA_G(g_o[1]),
        .VGA_B(b_o[1]), .VGA_HS(hs_o[1]), .VGA_VS(vs_o[1]), .snd_left(snd_left),
        .snd_right(snd_right), .AUDIO_L(al_o[1]), .AUDIO_R(ar_o[1]), .LED(led_o[1])
    );

    // ---------------- behavioural model ----------------
    // Instance 1 has every option enabled: signed audio, three buttons, active-low inputs.
    function automatic logic [9:0] m_joy(input logic [15:0] raw, input int k);
        logic [9:0] j;
        j = raw[9:0];
        if (k == 1) j = ~(j & 10'h07F);
        return j;
    endfunction

    function automatic logic [1:0] m_pair(input logic p2, input logic p1, input int k);
        logic [1:0] v;
        v = {p2, p1};
        return (k == 1) ? ~v : v;
    endfunction

    function automatic logic [5:0] m_col(input logic [3:0] c);
        return 6'(int'(c) * 4 + int'(c) / 4);
    endfunction

    function automatic logic [15:0] m_u(input logic [15:0] s, input int k);
        return (k == 1) ? 16'(int'(s) + 32768) : s;
    endfunction

    // Output bit is 1 whenever the running sum crosses a multiple of 65536.
    function automatic logic m_carry(input longint unsigned sum, input logic [15:0] u);
        return ((sum + 64'(u)) / 65536) != (sum / 65536);
    endfunction

    logic            m_hold;
    int              run;
    logic            e_rst_n, e_grst, e_pwe;
    logic [21:0]     e_paddr;
    logic [7:0]      e_pdata;
    logic [1:0]      e_pmask;
    logic [9:0]      e_joy1 [2], e_joy2 [2];
    logic [1:0]      e_coin [2], e_start [2];
    logic            e_pause, e_service [2];
    logic [5:0]      e_r, e_g, e_b;
    logic            e_hs, e_vs, e_led;
    longint unsigned sum_l [2], sum_r [2];
    logic            e_al [2], e_ar [2];

    assign m_hold = rst | ~pll_locked | downloading | rst_req;

    always @(posedge clk_sys) begin
        e_rst_n <= ~rst;
        if (m_hold) begin
            run    <= 0;
            e_grst <= 1'b0;
        end else begin
            run    <= (run < 1000) ? run + 1 : run;
            e_grst <= (run + 1) >= 256;
        end
        if (rst) begin
            e_pwe <= 1'b0; e_paddr <= '0; e_pdata <= '0; e_pmask <= 2'b11;
            e_pause <= 1'b0; e_led <= 1'b0;
            e_r <= '0; e_g <= '0; e_b <= '0; e_hs <= 1'b0; e_vs <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                e_joy1[k] <= m_joy(16'h0, k);
                e_joy2[k] <= m_joy(16'h0, k);
                e_coin[k] <= m_pair(1'b0, 1'b0, k);
                e_start[k] <= m_pair(1'b0, 1'b0, k);
                e_service[k] <= (k == 1);
                sum_l[k] <= 0; sum_r[k] <= 0; e_al[k] <= 1'b0; e_ar[k] <= 1'b0;
            end
        end else begin
            if (ioctl_wr && downloading) begin
                e_paddr <= 22'(ioctl_addr / 2);
                e_pdata <= ioctl_data;
                e_pmask <= (ioctl_addr % 2 == 1) ? 2'b01 : 2'b10;
                e_pwe   <= 1'b1;
            end else begin
                e_pwe   <= 1'b0;
            end
            e_pause <= joy1_raw[12] | joy2_raw[12];
            e_led   <= downloading;
            if (pxl_cen) begin
                e_r  <= (LHBL && LVBL) ? m_col(game_r) : 6'd0;
                e_g  <= (LHBL && LVBL) ? m_col(game_g) : 6'd0;
                e_b  <= (LHBL && LVBL) ? m_col(game_b) : 6'd0;
                e_hs <= hs;
                e_vs <= vs;
            end
            for (int k = 0; k < 2; k++) begin
                e_joy1[k]    <= m_joy(joy1_raw, k);
                e_joy2[k]    <= m_joy(joy2_raw, k);
                e_coin[k]    <= m_pair(joy2_raw[11], joy1_raw[11], k);
                e_start[k]   <= m_pair(joy2_raw[10], joy1_raw[10], k);
                e_service[k] <= (joy1_raw[13] | joy2_raw[13]) ^ (k == 1);
                e_al[k]      <= m_carry(sum_l[k], m_u(snd_left, k));
                e_ar[k]      <= m_carry(sum_r[k], m_u(snd_right, k));
                sum_l[k]     <= sum_l[k] + 64'(m_u(snd_left, k));
                sum_r[k]     <= sum_r[k] + 64'(m_u(snd_right, k));
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output of both instances.
    always @(posedge clk_sys) begin
        #1;
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk("rst_n", k, 32'(rst_n_o[k]), 32'(e_rst_n));
                chk("game_rst_n", k, 32'(game_rst_n_o[k]), 32'(e_grst));
                chk("prog_we", k, 32'(prog_we_o[k]), 32'(e_pwe));
                chk("prog_addr", k, 32'(prog_addr_o[k]), 32'(e_paddr));
                chk("prog_data", k, 32'(prog_data_o[k]), 32'(e_pdata));
                chk("prog_mask", k, 32'(prog_mask_o[k]), 32'(e_pmask));
                chk("joy1", k, 32'(joy1_o[k]), 32'(e_joy1[k]));
                chk("joy2", k, 32'(joy2_o[k]), 32'(e_joy2[k]));
                chk("coin", k, 32'(coin_o[k]), 32'(e_coin[k]));
                chk("start", k, 32'(start_o[k]), 32'(e_start[k]));
                chk("pause", k, 32'(pause_o[k]), 32'(e_pause));
                chk("service", k, 32'(service_o[k]), 32'(e_service[k]));
                chk("vga_rgb", k, 32'({r_o[k], g_o[k], b_o[k]}), 32'({e_r, e_g, e_b}));
                chk("vga_sync", k, 32'({hs_o[k], vs_o[k]}), 32'({e_hs, e_vs}));
                chk("audio_l", k, 32'(al_o[k]), 32'(e_al[k]));
                chk("audio_r", k, 32'(ar_o[k]), 32'(e_ar[k]));
                chk("led", k, 32'(led_o[k]), 32'(e_led));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_grst(input string name);
        int  n;
        bit  found;
        n = 0;
        found = 1'b0;
        while (n < 400 && !found) begin
            @(posedge clk_sys);
            #2;
            n++;
            if (game_rst_n_o[0] === 1'b1) found = 1'b1;
        end
        chk(name, 0, 32'(n), 32'd256);
    endtask

    task automatic count_ones(input int k, input bit left, output int ones);
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_sys);
            ones += int'(left ? al_o[k] : ar_o[k]);
        end
    endtask

    initial begin
        int ones;
        rst = 1'b1; pll_locked = 1'b1; rst_req = 1'b0; downloading = 1'b0;
        ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_data = '0;
        joy1_raw = '0; joy2_raw = '0; snd_left = '0; snd_right = '0;
        pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1; hs = 1'b0; vs = 1'b0;
        game_r = '0; game_g = '0; game_b = '0;

        @(posedge clk_sys);
        started = 1'b1;
        repeat (4) @(posedge clk_sys);
        #2;
        chk("lit_rst_n", 0, 32'(rst_n_o[0]), 32'd0);
        chk("lit_grst", 1, 32'(game_rst_n_o[1]), 32'd0);
        chk("lit_mask", 0, 32'(prog_mask_o[0]), 32'd3);
        chk("lit_joy_inact", 1, 32'(joy1_o[1]), 32'h3FF);
        chk("lit_coin_inact", 1, 32'(coin_o[1]), 32'd3);
        chk("lit_pause", 1, 32'(pause_o[1]), 32'd0);

        @(negedge clk_sys) rst = 1'b0;
        wait_grst("lit_grst_rise");

        // A short request re-arms the reset, then a mid-count request restarts it.
        @(negedge clk_sys) rst_req = 1'b1;
        @(negedge clk_sys) rst_req = 1'b0;
        repeat (100) @(negedge clk_sys);
        chk("lit_grst_mid", 0, 32'(game_rst_n_o[0]), 32'd0);
        rst_req = 1'b1;
        @(negedge clk_sys) rst_req = 1'b0;
        wait_grst("lit_grst_restart");

        @(negedge clk_sys);
        downloading = 1'b1; ioctl_addr = 22'h000101; ioctl_data = 8'hA5; ioctl_wr = 1'b1;
        @(negedge clk_sys) ioctl_wr = 1'b0;
        chk("lit_paddr_odd", 0, 32'(prog_addr_o[0]), 32'h80);
        chk("lit_pmask_odd", 0, 32'(prog_mask_o[0]), 32'd1);
        chk("lit_pdata", 0, 32'(prog_data_o[0]), 32'hA5);
        chk("lit_pwe_hi", 0, 32'(prog_we_o[0]), 32'd1);
        @(negedge clk_sys);
        chk("lit_pwe_lo", 0, 32'(prog_we_o[0]), 32'd0);
        ioctl_addr = 22'h000100; ioctl_data = 8'h5A; ioctl_wr = 1'b1;
        @(negedge clk_sys) ioctl_wr = 1'b0;
        chk("lit_pmask_even", 0, 32'(prog_mask_o[0]), 32'd2);
        chk("lit_paddr_even", 0, 32'(prog_addr_o[0]), 32'h80);
        downloading = 1'b0; ioctl_addr = 22'h3; ioctl_wr = 1'b1;
        @(negedge clk_sys) ioctl_wr = 1'b0;
        chk("lit_pwe_nodl", 0, 32'(prog_we_o[0]), 32'd0);
        for (int i = 0; i < 150; i++) begin
            @(negedge clk_sys);
            downloading = ($urandom_range(0, 9) != 0);
            ioctl_wr    = 1'($urandom);
            ioctl_addr  = 22'($urandom);
            ioctl_data  = 8'($urandom);
        end
        @(negedge clk_sys) begin downloading = 1'b0; ioctl_wr = 1'b0; end

        joy1_raw = 16'h0C01; joy2_raw = 16'h0000;
        @(negedge clk_sys);
        chk("lit_joy1", 0, 32'(joy1_o[0]), 32'h001);
        chk("lit_coin", 0, 32'(coin_o[0]), 32'd1);
        chk("lit_start", 0, 32'(start_o[0]), 32'd1);
        chk("lit_joy1_al", 1, 32'(joy1_o[1]), 32'h3FE);
        chk("lit_coin_al", 1, 32'(coin_o[1]), 32'd2);
        joy1_raw = 16'h0100;
        @(negedge clk_sys);
        chk("lit_3btn", 1, 32'(joy1_o[1]), 32'h3FF);
        chk("lit_btn8", 0, 32'(joy1_o[0]), 32'h100);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_sys);
            joy1_raw = 16'($urandom);
            joy2_raw = 16'($urandom);
        end

        @(negedge clk_sys) begin game_r = 4'hC; pxl_cen = 1'b1; LHBL = 1'b1; LVBL = 1'b1; end
        @(negedge clk_sys);
        chk("lit_vga_r", 0, 32'(r_o[0]), 32'h33);
        LHBL = 1'b0;
        @(negedge clk_sys);
        chk("lit_vga_blank", 0, 32'(r_o[0]), 32'h0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_sys);
            pxl_cen = 1'($urandom);
            LHBL = ($urandom_range(0, 3) != 0);
            LVBL = ($urandom_range(0, 3) != 0);
            hs = 1'($urandom); vs = 1'($urandom);
            game_r = 4'($urandom); game_g = 4'($urandom); game_b = 4'($urandom);
        end

        // Audio has seen only zero samples since reset.
        count_ones(1, 1'b1, ones);
        chk("lit_sd_half", 1, 32'(ones), 32'd8);
        count_ones(0, 1'b1, ones);
        chk("lit_sd_zero", 0, 32'(ones), 32'd0);
        snd_left = 16'h8000;
        @(negedge clk_sys);
        count_ones(1, 1'b1, ones);
        chk("lit_sd_signed_mid", 1, 32'(ones), 32'd0);
        count_ones(0, 1'b1, ones);
        chk("lit_sd_unsigned_mid", 0, 32'(ones), 32'd8);
        snd_left = 16'hFFFF; snd_right = 16'hFFFF;
        count_ones(0, 1'b0, ones);
        chk("lit_sd_full", 0, 32'(ones) >= 32'd15 ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_sys);
            if ($urandom_range(0, 7) == 0) snd_left  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) snd_right = 16'($urandom);
        end

        @(negedge clk_sys) rst = 1'b1;
        repeat (2) @(negedge clk_sys);
        rst = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk_sys);
            rst_req     = ($urandom_range(0, 31) == 0);
            pll_locked  = ($urandom_range(0, 31) != 0);
            downloading = ($urandom_range(0, 15) == 0);
            ioctl_wr    = 1'($urandom);
            ioctl_addr  = 22'($urandom);
            ioctl_data  = 8'($urandom);
            joy1_raw    = 16'($urandom);
            joy2_raw    = 16'($urandom);
            pxl_cen     = 1'($urandom);
            game_g      = 4'($urandom);
            snd_left    = 16'($urandom);
            snd_right   = 16'($urandom);
        end
        @(negedge clk_sys);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1);
    end

endmodule
